// File: rtl/sha_sched_pkg.sv
// Shared types and widths for the SHA nonce scheduler slice.
package sha_sched_pkg;

   localparam int unsigned NONCE_W  = 32;
   localparam int unsigned DIGEST_W = 32;
   localparam int unsigned ISSUE_W  = 33;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   // A digest word strictly below the target is a hit.
   function automatic logic digest_hit(input logic [DIGEST_W-1:0] digest,
                                       input logic [DIGEST_W-1:0] target);
      return digest < target;
   endfunction

endpackage

// File: rtl/sha_nonce_scheduler_if.sv
// Start/done handshake bundle between the scheduler and its bank of hash cores.
interface sha_nonce_scheduler_if
   import sha_sched_pkg::*;
#(
   parameter int unsigned NUM_CORES = 4
);

   logic [NUM_CORES-1:0]          core_start;
   logic [NUM_CORES*NONCE_W-1:0]  core_nonce;
   logic [NUM_CORES-1:0]          core_done;
   logic [NUM_CORES*DIGEST_W-1:0] core_digest;

   modport master (
      output core_start,
      output core_nonce,
      input  core_done,
      input  core_digest
   );

   modport slave (
      input  core_start,
      input  core_nonce,
      output core_done,
      output core_digest
   );

endinterface

// File: rtl/rr_free_picker.sv
// Combinational round-robin picker: first free slot at or after ptr, wrapping modulo N.
module rr_free_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     free_mask,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_valid_c,
   output logic [IDX_W-1:0] gnt_idx_c
);

   int j;

   always_comb begin
      gnt_valid_c = 1'b0;
      gnt_idx_c   = '0;
      j           = 0;
      for (int k = 0; k < int'(N); k++) begin
         j = int'(ptr) + k;
         if (j >= int'(N)) j = j - int'(N);
         if (!gnt_valid_c && free_mask[IDX_W'(j)]) begin
            gnt_valid_c = 1'b1;
            gnt_idx_c   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Shares NUM_CORES hash cores across a nonce sweep and records the first hit.
module sha_nonce_scheduler
   import sha_sched_pkg::*;
#(
   parameter int unsigned NUM_CORES    = 4,
   parameter bit          STOP_ON_FIND = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NONCE_W-1:0]   nonce_base,
   input  logic [NONCE_W-1:0]   nonce_count,
   input  logic [DIGEST_W-1:0]  target,
   sha_nonce_scheduler_if.master cores,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [NONCE_W-1:0]   found_nonce,
   output logic [31:0]          jobs_done
);

   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);

   sched_state_t          state_q;
   logic [NONCE_W-1:0]    base_q;
   logic [NONCE_W-1:0]    count_q;
   logic [DIGEST_W-1:0]   target_q;
   logic [ISSUE_W-1:0]    issued_q;
   logic [NUM_CORES-1:0]  slot_busy_q;
   logic [IDX_W-1:0]      ptr_q;
   logic [NONCE_W-1:0]    nonce_q [NUM_CORES];
   logic [NUM_CORES-1:0]  core_start_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  found_q;
   logic [NONCE_W-1:0]    found_nonce_q;
   logic [31:0]           jobs_done_q;

   logic                  gnt_valid;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  disp_ok;
   logic                  do_disp;
   logic [NUM_CORES-1:0]  gnt_mask;
   logic [NUM_CORES-1:0]  done_mask;
   logic [CNT_W-1:0]      done_cnt;
   logic                  hit_valid;
   logic [IDX_W-1:0]      hit_idx;
   logic [ISSUE_W-1:0]    issued_n;
   logic                  found_n;
   logic [NUM_CORES-1:0]  busy_n;
   logic                  disp_ok_n;
   logic                  active;

   rr_free_picker #(
      .N     (NUM_CORES),
      .IDX_W (IDX_W)
   ) u_picker (
      .free_mask   (~slot_busy_q),
      .ptr         (ptr_q),
      .gnt_valid_c (gnt_valid),
      .gnt_idx_c   (gnt_idx)
   );

   assign active    = (state_q == RUN) || (state_q == DRAIN);
   assign disp_ok   = (issued_q < {1'b0, count_q}) && !(STOP_ON_FIND && found_q);
   assign do_disp   = (state_q == RUN) && disp_ok && gnt_valid;
   assign gnt_mask  = do_disp ? (NUM_CORES'(1) << gnt_idx) : '0;
   assign issued_n  = issued_q + ISSUE_W'(do_disp);
   assign found_n   = found_q || hit_valid;
   assign busy_n    = (slot_busy_q & ~done_mask) | gnt_mask;
   assign disp_ok_n = (issued_n < {1'b0, count_q}) && !(STOP_ON_FIND && found_n);

   // Completions on busy slots only; lowest-index hit wins within a cycle.
   always_comb begin
      done_mask = '0;
      done_cnt  = '0;
      hit_valid = 1'b0;
      hit_idx   = '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
         if (active && cores.core_done[i] && slot_busy_q[i]) begin
            done_mask[i] = 1'b1;
            done_cnt     = done_cnt + CNT_W'(1);
            if (!found_q && !hit_valid &&
                digest_hit(cores.core_digest[i*DIGEST_W +: DIGEST_W], target_q)) begin
               hit_valid = 1'b1;
               hit_idx   = IDX_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         base_q        <= '0;
         count_q       <= '0;
         target_q      <= '0;
         issued_q      <= '0;
         slot_busy_q   <= '0;
         ptr_q         <= '0;
         core_start_q  <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         found_nonce_q <= '0;
         jobs_done_q   <= '0;
         for (int i = 0; i < int'(NUM_CORES); i++) nonce_q[i] <= '0;
      end else begin
         core_start_q <= '0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  base_q        <= nonce_base;
                  count_q       <= nonce_count;
                  target_q      <= target;
                  issued_q      <= '0;
                  ptr_q         <= '0;
                  found_q       <= 1'b0;
                  found_nonce_q <= '0;
                  jobs_done_q   <= '0;
                  if (nonce_count == '0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end
            end
            RUN, DRAIN: begin
               if (do_disp) begin
                  core_start_q     <= gnt_mask;
                  nonce_q[gnt_idx] <= base_q + issued_q[NONCE_W-1:0];
                  issued_q         <= issued_n;
                  ptr_q            <= (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0
                                                                         : gnt_idx + IDX_W'(1);
               end
               slot_busy_q <= busy_n;
               jobs_done_q <= jobs_done_q + 32'(done_cnt);
               if (hit_valid) begin
                  found_q       <= 1'b1;
                  found_nonce_q <= nonce_q[hit_idx];
               end
               // End-of-sweep decision looks at post-edge state so the last completion lands in DONE.
               if (!disp_ok_n) begin
                  if (busy_n == '0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= DRAIN;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cores.core_start = core_start_q;
   for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_nonce
      assign cores.core_nonce[g*NONCE_W +: NONCE_W] = nonce_q[g];
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign found_nonce = found_nonce_q;
   assign jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler: table-driven sweeps plus hand-written corner sequences.
module tb_sha_nonce_scheduler;

   localparam int NC = 4;
   localparam logic [31:0] TGT = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] nonce_base;
   logic [31:0] nonce_count;
   logic [31:0] target;
   logic        busy;
   logic        done;
   logic        found;
   logic [31:0] found_nonce;
   logic [31:0] jobs_done;

   sha_nonce_scheduler_if #(.NUM_CORES(NC)) bus ();

   sha_nonce_scheduler #(
      .NUM_CORES    (NC),
      .STOP_ON_FIND (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .nonce_base  (nonce_base),
      .nonce_count (nonce_count),
      .target      (target),
      .cores       (bus),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .found_nonce (found_nonce),
      .jobs_done   (jobs_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [31:0] count;
      int          lat;
      bit          hit_en;
      logic [31:0] hit_n;
      logic [31:0] hit_dg;
      logic [31:0] miss_dg;
      bit          exp_found;
      logic [31:0] exp_fn;
      int          exp_jobs;
   } vec_t;

   vec_t vecs [6];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] nonce_of(input int i);
      return bus.core_nonce[i*32 +: 32];
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [31:0] cnt);
      start       = 1'b1;
      nonce_base  = base;
      nonce_count = cnt;
      target      = TGT;
      step();
      start = 1'b0;
   endtask

   // Full sweep with a fixed-latency core model; records dispatch order and count.
   task automatic run_sweep(input vec_t v, output int issued, output bit order_ok,
                            output bit timed_out);
      int            rem [NC];
      logic [31:0]   nn [NC];
      logic [NC-1:0] cd;
      logic [127:0]  dg;
      int            cyc;
      for (int i = 0; i < NC; i++) begin
         rem[i] = 0;
         nn[i]  = '0;
      end
      issued   = 0;
      order_ok = 1'b1;
      pulse_start(v.base, v.count);
      cyc = 0;
      while (!done && cyc < 2000) begin
         if ($countones(bus.core_start) > 1) order_ok = 1'b0;
         for (int i = 0; i < NC; i++) begin
            if (bus.core_start[i]) begin
               if (rem[i] != 0) order_ok = 1'b0;
               if (nonce_of(i) !== v.base + 32'(issued)) order_ok = 1'b0;
               issued++;
               rem[i] = v.lat;
               nn[i]  = nonce_of(i);
            end
         end
         cd = '0;
         dg = '0;
         for (int i = 0; i < NC; i++) begin
            if (rem[i] == 1) begin
               cd[i] = 1'b1;
               dg[i*32 +: 32] = (v.hit_en && nn[i] == v.hit_n) ? v.hit_dg : v.miss_dg;
               rem[i] = 0;
            end else if (rem[i] > 1) begin
               rem[i] = rem[i] - 1;
            end
         end
         bus.core_done   = cd;
         bus.core_digest = dg;
         step();
         cyc++;
      end
      bus.core_done   = '0;
      bus.core_digest = '0;
      timed_out = !done;
   endtask

   task automatic check_sweep(input string tag, input vec_t v);
      int issued;
      bit order_ok;
      bit timed_out;
      run_sweep(v, issued, order_ok, timed_out);
      chk({tag, ".timeout"}, 64'(timed_out), 64'd0);
      chk({tag, ".order"}, 64'(order_ok), 64'd1);
      chk({tag, ".issued"}, 64'(issued), 64'(v.exp_jobs));
      chk({tag, ".jobs_done"}, 64'(jobs_done), 64'(v.exp_jobs));
      chk({tag, ".found"}, 64'(found), 64'(v.exp_found));
      chk({tag, ".found_nonce"}, 64'(found_nonce), 64'(v.exp_fn));
      chk({tag, ".done"}, 64'(done), 64'd1);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [NC-1:0] seen;
      vecs[0] = '{32'h0000_0100, 32'd8,   5, 1'b0, 32'h0,         32'h10,  TGT,           1'b0, 32'h0,         8};
      vecs[1] = '{32'h0000_0100, 32'd100, 5, 1'b1, 32'h0000_0102, 32'h10,  32'hFFFF_FFF0, 1'b1, 32'h0000_0102, 6};
      vecs[2] = '{32'hFFFF_FFFE, 32'd4,   3, 1'b0, 32'h0,         32'h10,  32'hFFFF_FFF0, 1'b0, 32'h0,         4};
      vecs[3] = '{32'h0000_0050, 32'd3,   2, 1'b1, 32'h0000_0052, TGT - 1, 32'hFFFF_FFF0, 1'b1, 32'h0000_0052, 3};
      vecs[4] = '{32'h0000_0010, 32'd10,  1, 1'b0, 32'h0,         32'h10,  TGT + 1,       1'b0, 32'h0,         10};
      vecs[5] = '{32'h0000_0200, 32'd50,  4, 1'b1, 32'h0000_0200, 32'h0,   32'hFFFF_FFF0, 1'b1, 32'h0000_0200, 4};

      reset = 1'b1; start = 1'b0; nonce_base = '0; nonce_count = '0; target = '0;
      bus.core_done = '0; bus.core_digest = '0;
      step();
      step();
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.found", 64'(found), 64'd0);
      chk("reset.found_nonce", 64'(found_nonce), 64'd0);
      chk("reset.jobs_done", 64'(jobs_done), 64'd0);
      chk("reset.core_start", 64'(bus.core_start), 64'd0);
      chk("reset.core_nonce", 64'(bus.core_nonce[63:0]), 64'd0);
      reset = 1'b0;

      for (int k = 0; k < 6; k++) check_sweep($sformatf("vec%0d", k), vecs[k]);

      // Zero count: done right after start, no dispatches.
      pulse_start(32'h0000_0700, 32'd0);
      chk("zero.done", 64'(done), 64'd1);
      chk("zero.busy", 64'(busy), 64'd0);
      chk("zero.jobs_done", 64'(jobs_done), 64'd0);
      seen = '0;
      for (int c = 0; c < 4; c++) begin
         seen = seen | bus.core_start;
         step();
      end
      chk("zero.no_start", 64'(seen), 64'd0);
      chk("zero.done_held", 64'(done), 64'd1);

      // Simultaneous hits on cores 1 and 3; also a start during RUN is ignored.
      do_reset();
      pulse_start(32'h0000_0300, 32'd4);
      step();
      chk("simul.first_start", 64'(bus.core_start), 64'b0001);
      chk("simul.nonce0", 64'(nonce_of(0)), 64'h300);
      start = 1'b1; nonce_base = 32'h0000_0999; nonce_count = 32'd1;
      step();
      start = 1'b0;
      chk("simul.second_start", 64'(bus.core_start), 64'b0010);
      chk("simul.nonce1", 64'(nonce_of(1)), 64'h301);
      step();
      chk("simul.nonce2", 64'(nonce_of(2)), 64'h302);
      step();
      chk("simul.nonce3", 64'(nonce_of(3)), 64'h303);
      chk("simul.busy", 64'(busy), 64'd1);
      bus.core_done   = 4'b1010;
      bus.core_digest = {32'h1, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF};
      step();
      bus.core_done = '0;
      chk("simul.found", 64'(found), 64'd1);
      chk("simul.found_nonce", 64'(found_nonce), 64'h301);
      chk("simul.jobs2", 64'(jobs_done), 64'd2);
      chk("simul.not_done", 64'(done), 64'd0);
      bus.core_done   = 4'b0101;
      bus.core_digest = {32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'h0};
      step();
      bus.core_done = '0;
      chk("simul.found_nonce_held", 64'(found_nonce), 64'h301);
      chk("simul.jobs4", 64'(jobs_done), 64'd4);
      chk("simul.done", 64'(done), 64'd1);
      chk("simul.busy_low", 64'(busy), 64'd0);

      // Stray done on a free core is ignored.
      do_reset();
      pulse_start(32'h0000_0400, 32'd2);
      step();
      step();
      bus.core_done   = 4'b0100;
      bus.core_digest = '0;
      step();
      chk("stray.jobs0", 64'(jobs_done), 64'd0);
      chk("stray.found0", 64'(found), 64'd0);
      bus.core_done   = 4'b0001;
      bus.core_digest = {4{32'hFFFF_FFFF}};
      step();
      chk("stray.jobs1", 64'(jobs_done), 64'd1);
      chk("stray.not_done", 64'(done), 64'd0);
      bus.core_done = 4'b0010;
      step();
      bus.core_done = '0;
      chk("stray.jobs2", 64'(jobs_done), 64'd2);
      chk("stray.done", 64'(done), 64'd1);
      chk("stray.found", 64'(found), 64'd0);

      // Reset mid-sweep, then a fresh sweep.
      do_reset();
      pulse_start(32'h0000_0500, 32'd20);
      step();
      step();
      bus.core_done   = 4'b0001;
      bus.core_digest = '0;
      step();
      bus.core_done = '0;
      chk("midrst.busy_before", 64'(busy), 64'd1);
      chk("midrst.found_before", 64'(found), 64'd1);
      reset = 1'b1;
      step();
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.found", 64'(found), 64'd0);
      chk("midrst.found_nonce", 64'(found_nonce), 64'd0);
      chk("midrst.jobs_done", 64'(jobs_done), 64'd0);
      chk("midrst.core_start", 64'(bus.core_start), 64'd0);
      chk("midrst.done", 64'(done), 64'd0);
      reset = 1'b0;
      check_sweep("after_rst",
                  '{32'h0000_0600, 32'd5, 2, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b0, 32'h0, 5});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
